// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle sequencer, alu_control and the datapath muxes.
// Contents: opcode constants, FSM state type, ALU/mux select codes and the
// packed control vector produced by ctrl_out_decode.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Encodings 12..15 are unreachable; the FSM routes them to StTrap.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBeq    = 4'd9,
    StJal    = 4'd10,
    StTrap   = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] WB_ALUOUT  = 2'b00;
  localparam logic [1:0] WB_MDR     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer (master) and the datapath (slave).
// Carries enable/opcode/zero/mem_ready into the controller and the control
// strobes, illegal flag and retired-instruction count out of it.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic             enable;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       MemToReg;
  logic             RegWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             PCSource;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  enable, opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, retired
  );

  modport slave (
    output enable, opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_ctrl_out_decode.sv
// Moore output decode for the multicycle sequencer.
// Ports: state (current FSM state), enable/mem_ready (FETCH qualifiers),
// ctrl (full control vector; unlisted fields are 0).
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   enable,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        if (enable) begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_a = SRCA_PC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          // IR and PC only load once the instruction word is actually there.
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
      end
      StDecode: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      StMemAdr: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_MDR;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StExecR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_RFUNCT;
      end
      StExecI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IFUNCT;
      end
      StAluWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_ALUOUT;
      end
      StBeq: begin
        ctrl.alu_src_a     = SRCA_RS1;
        ctrl.alu_src_b     = SRCB_RS2;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      StJal: begin
        // PC already holds old_pc+4 (link value); ALUOut holds the target.
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 1'b1;
      end
      StTrap: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the mini RISC-V datapath: steps FETCH/DECODE/EXEC/MEM/WB,
// waits on mem_ready, stalls on enable=0 in FETCH and counts retired instructions.
// Ports: clock, reset_n (async active-low), bus (master side of multicycle_control_if).
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  multicycle_control_if.master   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl, ctrl_gated;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (bus.enable && bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = StMemAdr;
          OP_R:              state_d = StExecR;
          OP_I:              state_d = StExecI;
          OP_BRANCH:         state_d = StBeq;
          OP_JAL:            state_d = StJal;
          default:           state_d = StTrap;
        endcase
      end
      // opcode[5] separates store (0100011) from load (0000011).
      StMemAdr: state_d = bus.opcode[5] ? StMemWr : StMemRd;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StAluWb, StBeq, StJal: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  ctrl_out_decode u_decode (
    .state     (state_q),
    .enable    (bus.enable),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes must drop the instant reset asserts, not at the next edge.
  assign ctrl_gated      = reset_n ? ctrl : '0;

  assign bus.PCWrite     = ctrl_gated.pc_write;
  assign bus.PCWriteCond = ctrl_gated.pc_write_cond;
  assign bus.IorD        = ctrl_gated.i_or_d;
  assign bus.MemRead     = ctrl_gated.mem_read;
  assign bus.MemWrite    = ctrl_gated.mem_write;
  assign bus.IRWrite     = ctrl_gated.ir_write;
  assign bus.MemToReg    = ctrl_gated.mem_to_reg;
  assign bus.RegWrite    = ctrl_gated.reg_write;
  assign bus.ALUSrcA     = ctrl_gated.alu_src_a;
  assign bus.ALUSrcB     = ctrl_gated.alu_src_b;
  assign bus.ALUOp       = ctrl_gated.alu_op;
  assign bus.PCSource    = ctrl_gated.pc_source;
  assign bus.illegal     = ctrl_gated.illegal;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of instructions with per-cycle
// expected control vectors, plus hand sequences for waits, stalls, trap and reset.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(.CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegWrite,
  //  ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal}
  logic [16:0] out_vec;
  assign out_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemToReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                    bus.ALUOp, bus.PCSource, bus.illegal};

  localparam logic [16:0] VZ  = 17'b0_0_0_0_0_0_00_0_00_00_00_0_0;
  localparam logic [16:0] VF  = 17'b1_0_0_1_0_1_00_0_00_01_00_0_0;
  localparam logic [16:0] VFW = 17'b0_0_0_1_0_0_00_0_00_01_00_0_0;
  localparam logic [16:0] VD  = 17'b0_0_0_0_0_0_00_0_10_10_00_0_0;
  localparam logic [16:0] VMA = 17'b0_0_0_0_0_0_00_0_01_10_00_0_0;
  localparam logic [16:0] VMR = 17'b0_0_1_1_0_0_00_0_00_00_00_0_0;
  localparam logic [16:0] VMB = 17'b0_0_0_0_0_0_01_1_00_00_00_0_0;
  localparam logic [16:0] VMW = 17'b0_0_1_0_1_0_00_0_00_00_00_0_0;
  localparam logic [16:0] VER = 17'b0_0_0_0_0_0_00_0_01_00_10_0_0;
  localparam logic [16:0] VEI = 17'b0_0_0_0_0_0_00_0_01_10_11_0_0;
  localparam logic [16:0] VAW = 17'b0_0_0_0_0_0_00_1_00_00_00_0_0;
  localparam logic [16:0] VBQ = 17'b0_1_0_0_0_0_00_0_01_00_01_1_0;
  localparam logic [16:0] VJ  = 17'b1_0_0_0_0_0_10_1_00_00_00_1_0;
  localparam logic [16:0] VT  = 17'b0_0_0_0_0_0_00_0_00_00_00_0_1;

  typedef struct {
    string            name;
    logic [6:0]       op;
    logic             z;
    int               len;
    logic [4:0][16:0] seq;  // seq[0] is the FETCH cycle
  } vec_t;

  vec_t  tbl[7];
  int    n_checks = 0;
  int    n_errors = 0;
  logic [31:0] exp_ret = 0;

  task automatic check_vec(input string name, input logic [16:0] exp);
    n_checks++;
    if (out_vec !== exp) begin
      n_errors++;
      $display("FAIL %s: ctrl got %b want %b", name, out_vec, exp);
    end
  endtask

  task automatic check_ret(input string name);
    n_checks++;
    if (bus.retired !== exp_ret) begin
      n_errors++;
      $display("FAIL %s: retired got %0d want %0d", name, bus.retired, exp_ret);
    end
  endtask

  // Drive inputs just after a posedge, sample at the following negedge.
  task automatic step(input logic en, input logic mr, input logic [16:0] exp,
                      input string name);
    bus.enable    = en;
    bus.mem_ready = mr;
    @(negedge clock);
    check_vec(name, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input int idx);
    bus.opcode = tbl[idx].op;
    bus.zero   = tbl[idx].z;
    for (int c = 0; c < tbl[idx].len; c++) begin
      step(1'b1, 1'b1, tbl[idx].seq[c], $sformatf("%s_c%0d", tbl[idx].name, c));
    end
    exp_ret++;
    check_ret({tbl[idx].name, "_retired"});
  endtask

  initial begin
    tbl[0] = '{"R",     7'b0110011, 1'b0, 4, {VZ, VAW, VER, VD, VF}};
    tbl[1] = '{"I",     7'b0010011, 1'b0, 4, {VZ, VAW, VEI, VD, VF}};
    tbl[2] = '{"lw",    7'b0000011, 1'b0, 5, {VMB, VMR, VMA, VD, VF}};
    tbl[3] = '{"sw",    7'b0100011, 1'b0, 4, {VZ, VMW, VMA, VD, VF}};
    tbl[4] = '{"beq_z1", 7'b1100011, 1'b1, 3, {VZ, VZ, VBQ, VD, VF}};
    tbl[5] = '{"beq_z0", 7'b1100011, 1'b0, 3, {VZ, VZ, VBQ, VD, VF}};
    tbl[6] = '{"jal",   7'b1101111, 1'b0, 3, {VZ, VZ, VJ, VD, VF}};

    // Reset held 3 cycles with live inputs: strobes must stay gated off.
    reset_n       = 1'b0;
    bus.opcode    = 7'b0110011;
    bus.zero      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, VZ, $sformatf("reset_c%0d", i));
      check_ret("reset_retired");
    end
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // FETCH stall: enable=0 for 5 cycles, then a normal R instruction proves state held.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, VZ, $sformatf("stall_c%0d", i));
    check_ret("stall_retired");
    run_vec(0);

    // lw with a 2-cycle fetch wait and a 2-cycle MEMRD wait.
    bus.opcode = 7'b0000011;
    step(1'b1, 1'b0, VFW, "lw_fetch_wait0");
    step(1'b1, 1'b0, VFW, "lw_fetch_wait1");
    step(1'b1, 1'b1, VF,  "lw_fetch");
    step(1'b1, 1'b0, VD,  "lw_decode");
    step(1'b1, 1'b0, VMA, "lw_memadr");
    step(1'b1, 1'b0, VMR, "lw_memrd_wait0");
    step(1'b1, 1'b0, VMR, "lw_memrd_wait1");
    check_ret("lw_wait_no_retire");
    step(1'b1, 1'b1, VMR, "lw_memrd_ready");
    step(1'b1, 1'b0, VMB, "lw_memwb");
    exp_ret++;
    check_ret("lw_wait_retired");

    // Illegal opcode: TRAP absorbs regardless of enable/mem_ready.
    bus.opcode = 7'b1111111;
    step(1'b1, 1'b1, VF, "trap_fetch");
    step(1'b1, 1'b1, VD, "trap_decode");
    for (int i = 0; i < 10; i++) begin
      step(i[0], ~i[0], VT, $sformatf("trap_c%0d", i));
    end
    check_ret("trap_retired");
    reset_n = 1'b0;
    exp_ret = 0;
    #1;
    check_vec("trap_reset_async", VZ);
    check_ret("trap_reset_retired");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b1, VZ, "post_trap_idle");
    run_vec(6);

    // Reset dropped mid-MEMWR: MemWrite falls at once, no retire.
    bus.opcode = 7'b0100011;
    step(1'b1, 1'b1, VF,  "swrst_fetch");
    step(1'b1, 1'b1, VD,  "swrst_decode");
    step(1'b1, 1'b1, VMA, "swrst_memadr");
    step(1'b1, 1'b0, VMW, "swrst_memwr_wait");
    check_ret("swrst_pre_reset");
    #2;
    check_vec("swrst_memwr_held", VMW);
    reset_n = 1'b0;
    exp_ret = 0;
    #1;
    check_vec("swrst_async_drop", VZ);
    check_ret("swrst_retired");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b1, VZ, "swrst_idle");
    check_ret("swrst_retired_after");
    run_vec(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
